instruction_register: RTL and testbench
=======================================

Name: instruction_register

Overview:
Instruction register (IR) of the simple microprocessor datapath. It captures the 21-bit instruction word read from instruction RAM when the controller asserts IR_Load. It holds that word and presents it split into its fixed fields: opcode, two source register addresses and a destination register address. These fields drive the control unit and the register-file address ports.

Parameters:
INST_WIDTH, 21, instruction word width (`INST_WIDTH); must equal OPCODE_WIDTH + 3*ADDR_WIDTH
OPCODE_WIDTH, 3, opcode field width (`OPCODE_WIDTH)
ADDR_WIDTH, 6, register-address field width (`ADDR_WIDTH)

Ports:
Clk  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
IR_Load  input  1  load enable; capture Ram_Inst_Out on the rising Clk edge while high
Ram_Inst_Out  input  INST_WIDTH  instruction word from instruction RAM
Opcode  output  OPCODE_WIDTH  held instruction bits [20:18]
Source_Reg1  output  ADDR_WIDTH  held instruction bits [17:12]
Source_Reg2  output  ADDR_WIDTH  held instruction bits [11:6]
Dest_Reg  output  ADDR_WIDTH  held instruction bits [5:0]
Inst_Out  output  INST_WIDTH  full held instruction word
Opcode_OneHot  output  2**OPCODE_WIDTH  one-hot decode of Opcode (bit n high when Opcode==n)
Inst_Valid  output  1  high once at least one instruction has been loaded since reset

Behaviour:
- Single INST_WIDTH-bit storage register plus the Inst_Valid flop; all outputs derive combinationally from this storage (no input-to-output combinational path).
- Reset high (asynchronous, any time): storage cleared to 0 and Inst_Valid=0 immediately. Outputs then read Opcode=0, all register fields=0, Inst_Out=0, Opcode_OneHot=8'b0000_0001, Inst_Valid=0.
- Reset has priority over IR_Load. Reset and load asserted together: the register stays cleared.
- Rising Clk edge, Reset low, IR_Load=1: storage <= Ram_Inst_Out; Inst_Valid <= 1.
- Rising Clk edge, IR_Load=0: storage and Inst_Valid hold. Ram_Inst_Out changes are ignored.
- Latency: new fields are visible right after the capturing edge and are stable for the whole following cycle. Ram_Inst_Out must be stable at that edge.
- IR_Load held high over consecutive edges: every edge reloads, so the last sampled word wins.
- Field slicing is fixed MSB-first: Opcode = storage[INST_WIDTH-1 -: OPCODE_WIDTH], Source_Reg1 next ADDR_WIDTH bits, Source_Reg2 next, Dest_Reg = storage[ADDR_WIDTH-1:0].
- Opcode_OneHot: exactly one bit set at all times outside X inputs.
- Reset deassertion takes effect asynchronously. The first load can occur on the next rising edge.
- No handshake or back-pressure; load is a plain enable.

Test Plan:
1. Reset=1 for 2 cycles, then release -> all fields 0, Inst_Out=0, Opcode_OneHot=00000001, Inst_Valid=0.
2. Ram_Inst_Out=101_000011_000101_111111, IR_Load=1 for one edge -> Opcode=101, Source_Reg1=000011, Source_Reg2=000101, Dest_Reg=111111, Opcode_OneHot=00100000, Inst_Valid=1.
3. IR_Load=0, change Ram_Inst_Out to all-ones for 3 cycles -> outputs unchanged from scenario 2.
4. 100 random 21-bit words (value mod 2097152), each loaded with a 1-cycle IR_Load pulse -> after each edge the fields equal bits [20:18], [17:12], [11:6], [5:0] of that word.
5. IR_Load held high for 3 edges with words 0x1FFFFF, 0x000000, 0x0AAAAA -> after each edge outputs reflect that edge's word. Final: Opcode=010, Source_Reg1=101010, Source_Reg2=101010, Dest_Reg=101010.
6. Reset asserted mid-cycle while a word is held, and also asserted together with IR_Load=1 -> outputs clear immediately without waiting for a clock edge and stay 0 through the edge. Inst_Valid=0.

Source files
------------

// File: rtl/instruction_register.sv
// Instruction register: captures the instruction word on IR_Load and presents
// its fixed MSB-first fields, a one-hot opcode decode and a loaded flag.
module instruction_register #(
  parameter int INST_WIDTH   = 21,
  parameter int OPCODE_WIDTH = 3,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         IR_Load,
  input  logic [INST_WIDTH-1:0]        Ram_Inst_Out,
  output logic [OPCODE_WIDTH-1:0]      Opcode,
  output logic [ADDR_WIDTH-1:0]        Source_Reg1,
  output logic [ADDR_WIDTH-1:0]        Source_Reg2,
  output logic [ADDR_WIDTH-1:0]        Dest_Reg,
  output logic [INST_WIDTH-1:0]        Inst_Out,
  output logic [(2**OPCODE_WIDTH)-1:0] Opcode_OneHot,
  output logic                         Inst_Valid
);

  localparam int SRC1_LSB = 2 * ADDR_WIDTH;
  localparam int SRC2_LSB = ADDR_WIDTH;

  logic [INST_WIDTH-1:0] inst_p0;
  logic                  vld_p0;

  // Stage p0: the held instruction word and its loaded flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inst_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (IR_Load) begin
      inst_p0 <= Ram_Inst_Out;
      vld_p0  <= 1'b1;
    end
  end

  assign Inst_Out    = inst_p0;
  assign Inst_Valid  = vld_p0;
  assign Opcode      = inst_p0[INST_WIDTH-1 -: OPCODE_WIDTH];
  assign Source_Reg1 = inst_p0[SRC1_LSB +: ADDR_WIDTH];
  assign Source_Reg2 = inst_p0[SRC2_LSB +: ADDR_WIDTH];
  assign Dest_Reg    = inst_p0[ADDR_WIDTH-1:0];

  always_comb begin
    Opcode_OneHot         = '0;
    Opcode_OneHot[Opcode] = 1'b1;
  end

endmodule

// File: tb/tb_instruction_register.sv
// Randomized bench for instruction_register with a field-level reference model.
module tb_instruction_register;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        IR_Load = 1'b0;
  logic [20:0] Ram_Inst_Out = '0;
  logic [2:0]  Opcode;
  logic [5:0]  Source_Reg1, Source_Reg2, Dest_Reg;
  logic [20:0] Inst_Out;
  logic [7:0]  Opcode_OneHot;
  logic        Inst_Valid;

  int npass = 0;
  int ntotal = 0;
  bit cmp_en = 1'b0;

  int unsigned exp_word = 0;
  bit          exp_valid = 1'b0;

  instruction_register #(.INST_WIDTH(21), .OPCODE_WIDTH(3), .ADDR_WIDTH(6)) dut (
    .Clk(Clk), .Reset(Reset), .IR_Load(IR_Load), .Ram_Inst_Out(Ram_Inst_Out),
    .Opcode(Opcode), .Source_Reg1(Source_Reg1), .Source_Reg2(Source_Reg2),
    .Dest_Reg(Dest_Reg), .Inst_Out(Inst_Out), .Opcode_OneHot(Opcode_OneHot),
    .Inst_Valid(Inst_Valid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    ntotal++;
    if (act == req) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference: fields by plain arithmetic on the expected word
  task automatic check_all(input string tag);
    chk({tag, " opcode"}, Opcode,        exp_word / 262144);
    chk({tag, " src1"},   Source_Reg1,   (exp_word / 4096) % 64);
    chk({tag, " src2"},   Source_Reg2,   (exp_word / 64) % 64);
    chk({tag, " dest"},   Dest_Reg,      exp_word % 64);
    chk({tag, " inst"},   Inst_Out,      exp_word);
    chk({tag, " onehot"}, Opcode_OneHot, 1 << (exp_word / 262144));
    chk({tag, " valid"},  Inst_Valid,    exp_valid);
  endtask

  always @(negedge Clk) if (cmp_en) check_all("cycle");

  task automatic load(input logic [20:0] w, input bit keep);
    @(negedge Clk); #1;
    IR_Load = 1'b1;
    Ram_Inst_Out = w;
    @(posedge Clk); #1;
    exp_word = w;
    exp_valid = 1'b1;
    if (!keep) IR_Load = 1'b0;
    Ram_Inst_Out = 21'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk); #1;
      IR_Load = 1'b0;
      Ram_Inst_Out = 21'($urandom);
    end
  endtask

  initial begin
    // 1: reset for two cycles, then release
    repeat (2) @(posedge Clk);
    #1 cmp_en = 1'b1;
    @(negedge Clk); #1 Reset = 1'b0;
    idle(1);
    chk("reset onehot literal", Opcode_OneHot, 8'b0000_0001);
    chk("reset valid literal", Inst_Valid, 0);

    // 2: single load of a known word
    load(21'b101_000011_000101_111111, 1'b0);
    chk("s2 opcode literal", Opcode, 3'b101);
    chk("s2 src1 literal", Source_Reg1, 6'b000011);
    chk("s2 src2 literal", Source_Reg2, 6'b000101);
    chk("s2 dest literal", Dest_Reg, 6'b111111);
    chk("s2 onehot literal", Opcode_OneHot, 8'b0010_0000);

    // 3: input changes ignored without load
    repeat (3) begin
      @(negedge Clk); #1;
      IR_Load = 1'b0;
      Ram_Inst_Out = 21'h1FFFFF;
    end
    @(posedge Clk); #1;
    chk("s3 hold inst literal", Inst_Out, 21'b101_000011_000101_111111);

    // 4: random single-cycle loads with random gaps
    for (int i = 0; i < 100; i++) begin
      load(21'($urandom % 2097152), 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    // 5: load held high across consecutive edges
    load(21'h1FFFFF, 1'b1);
    load(21'h000000, 1'b1);
    load(21'h0AAAAA, 1'b0);
    chk("s5 opcode literal", Opcode, 3'b010);
    chk("s5 src1 literal", Source_Reg1, 6'b101010);
    chk("s5 src2 literal", Source_Reg2, 6'b101010);
    chk("s5 dest literal", Dest_Reg, 6'b101010);

    // 6: asynchronous reset mid-cycle, then together with a load
    load(21'h15A5A5, 1'b0);
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    exp_word = 0;
    exp_valid = 1'b0;
    check_all("async reset");
    IR_Load = 1'b1;
    Ram_Inst_Out = 21'h1ABCDE;
    @(posedge Clk); #1;
    check_all("reset with load");
    @(negedge Clk); #1;
    Reset = 1'b0;
    IR_Load = 1'b0;
    idle(1);
    load(21'h0C3A5F, 1'b0);
    idle(2);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
